// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the single register-file write port between the
// pipeline writeback and a small FIFO of deferred load returns. Pipeline
// writes always win. Load returns drain on idle write-port cycles. A younger
// pipeline write to the same register squashes a pending load return. When
// the FIFO is blocked too long, the block raises a registered stall request.

// One FIFO slot. It holds dest/value plus a live bit. The slot also compares
// its dest against the decode sources for hazard detection.
module wb_write_arbiter_entry #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              squash,
  input  logic [ADDR_W-1:0] squash_dest,
  input  logic [ADDR_W-1:0] wr_dest,
  input  logic [DATA_W-1:0] wr_value,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  output logic [ADDR_W-1:0] dest,
  output logic [DATA_W-1:0] value,
  output logic              live,
  output logic              hit
);
  // A push wins over squash: a load landing this cycle is younger than the
  // pipeline write. A pop kills the live bit so a drained slot raises no hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest  <= '0;
      value <= '0;
      live  <= 1'b0;
    end else if (push) begin
      dest  <= wr_dest;
      value <= wr_value;
      live  <= 1'b1;
    end else if (pop) begin
      live  <= 1'b0;
    end else if (squash && dest == squash_dest) begin
      live  <= 1'b0;
    end
  end

  assign hit = live && (dest == src1 || dest == src2);
endmodule

module wb_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_wb_en,
  input  logic [ADDR_W-1:0]        pipe_dest,
  input  logic [DATA_W-1:0]        pipe_value,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_dest,
  input  logic [DATA_W-1:0]        ld_value,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        src1,
  input  logic [ADDR_W-1:0]        src2,
  output logic                     hazard,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_dest,
  output logic [DATA_W-1:0]        rf_value,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [PW-1:0]                  head, tail;
  logic [DEPTH-1:0][ADDR_W-1:0]   e_dest;
  logic [DEPTH-1:0][DATA_W-1:0]   e_value;
  logic [DEPTH-1:0]               e_live;
  logic [DEPTH-1:0]               e_hit;
  logic [DEPTH-1:0]               e_push, e_pop;
  logic                           push, pop, not_empty;
  logic [SW-1:0]                  starve, starve_nxt;

  assign not_empty = (count != '0);
  // No pass-through: ready depends only on the current occupancy.
  assign ld_ready  = (count < CW'(DEPTH));
  assign push      = ld_valid && ld_ready;
  assign pop       = !pipe_wb_en && not_empty;
  assign hazard    = |e_hit;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign e_push[i] = push && (tail == PW'(i));
    assign e_pop[i]  = pop  && (head == PW'(i));
    wb_write_arbiter_entry #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ent (
      .clk         (clk),
      .rst         (rst),
      .push        (e_push[i]),
      .pop         (e_pop[i]),
      .squash      (pipe_wb_en),
      .squash_dest (pipe_dest),
      .wr_dest     (ld_dest),
      .wr_value    (ld_value),
      .src1        (src1),
      .src2        (src2),
      .dest        (e_dest[i]),
      .value       (e_value[i]),
      .live        (e_live[i]),
      .hit         (e_hit[i])
    );
  end

  // Write-port grant: pipeline first, then FIFO head (squashed head burns the slot).
  always_comb begin
    rf_we    = 1'b0;
    rf_dest  = '0;
    rf_value = '0;
    if (pipe_wb_en) begin
      rf_we    = 1'b1;
      rf_dest  = pipe_dest;
      rf_value = pipe_value;
    end else if (not_empty) begin
      rf_we    = e_live[head];
      rf_dest  = e_dest[head];
      rf_value = e_value[head];
    end
  end

  // Pointers wrap modulo DEPTH. The occupancy moves only on unbalanced push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= (tail == PW'(DEPTH - 1)) ? '0 : tail + 1'b1;
      if (pop)  head <= (head == PW'(DEPTH - 1)) ? '0 : head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Count consecutive cycles where the pipeline blocks a non-empty FIFO.
  always_comb begin
    starve_nxt = starve;
    if (pop || !not_empty)
      starve_nxt = '0;
    else if (pipe_wb_en && starve != SW'(STARVE_MAX))
      starve_nxt = starve + 1'b1;
  end

  // Stall is raised when starvation saturates and held until the FIFO pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve    <= '0;
      stall_req <= 1'b0;
    end else begin
      starve <= starve_nxt;
      if (pop)
        stall_req <= 1'b0;
      else if (starve_nxt == SW'(STARVE_MAX))
        stall_req <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter. Inputs change at the falling edge, and
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_wb_write_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_en;
  logic [3:0]  pipe_dest;
  logic [31:0] pipe_value;
  logic        ld_valid;
  logic [3:0]  ld_dest;
  logic [31:0] ld_value;
  logic        ld_ready;
  logic [3:0]  src1, src2;
  logic        hazard;
  logic        rf_we;
  logic [3:0]  rf_dest;
  logic [31:0] rf_value;
  logic        stall_req;
  logic [1:0]  count;

  int n_chk = 0;
  int n_fail = 0;

  wb_write_arbiter #(.DATA_W(32), .ADDR_W(4), .DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_en(pipe_wb_en), .pipe_dest(pipe_dest), .pipe_value(pipe_value),
    .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_value(ld_value), .ld_ready(ld_ready),
    .src1(src1), .src2(src2), .hazard(hazard),
    .rf_we(rf_we), .rf_dest(rf_dest), .rf_value(rf_value),
    .stall_req(stall_req), .count(count)
  );

  always #5 clk = ~clk;

  // While stall_req is asserted, the pipeline must not drive a write.
  always @(posedge clk)
    if (!rst && stall_req && pipe_wb_en) begin
      n_fail++;
      $display("FAIL stall_protocol: pipe_wb_en=1 while stall_req=1");
    end

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic pw, input logic [3:0] pd, input logic [31:0] pv,
                       input logic lv, input logic [3:0] ldd, input logic [31:0] ldv);
    pipe_wb_en = pw; pipe_dest = pd; pipe_value = pv;
    ld_valid = lv; ld_dest = ldd; ld_value = ldv;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; src1 = 4'd0; src2 = 4'd0;
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    n_chk++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_chk++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
    n_chk++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b want 0", hazard); end
    n_chk++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we_idle: got %b want 0", rf_we); end
    drive(1'b1, 4'd1, 32'h5, 1'b0, 4'd0, 32'd0);
    n_chk++; if (rf_we !== 1'b1 || rf_dest !== 4'd1 || rf_value !== 32'h5)
      begin n_fail++; $display("FAIL reset_pipe_passthru: got we=%b d=%0d v=%h want 1/1/5", rf_we, rf_dest, rf_value); end
    next_cyc();
    rst = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    next_cyc();
  endtask

  task automatic test_load_basic();
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'hAAAA);
    n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL basic_no_write_push_cycle: got %b want 0", rf_we); end
    next_cyc();
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    n_chk++; if (count !== 2'd1) begin n_fail++; $display("FAIL basic_count1: got %0d want 1", count); end
    n_chk++; if (rf_we !== 1'b1 || rf_dest !== 4'd3 || rf_value !== 32'hAAAA)
      begin n_fail++; $display("FAIL basic_drain: got we=%b d=%0d v=%h want 1/3/aaaa", rf_we, rf_dest, rf_value); end
    next_cyc();
    n_chk++; if (count !== 2'd0 || rf_we !== 1'b0)
      begin n_fail++; $display("FAIL basic_empty: got count=%0d we=%b want 0/0", count, rf_we); end
  endtask

  task automatic test_pipe_priority();
    src1 = 4'd6; src2 = 4'd0;
    drive(1'b1, 4'd5, 32'h11, 1'b1, 4'd6, 32'h66);
    n_chk++; if (rf_we !== 1'b1 || rf_dest !== 4'd5 || rf_value !== 32'h11)
      begin n_fail++; $display("FAIL prio_pipe: got we=%b d=%0d v=%h want 1/5/11", rf_we, rf_dest, rf_value); end
    n_chk++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL prio_hazard_push_cycle: got %b want 0", hazard); end
    next_cyc();
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    n_chk++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL prio_hazard_between: got %b want 1", hazard); end
    n_chk++; if (rf_we !== 1'b1 || rf_dest !== 4'd6 || rf_value !== 32'h66)
      begin n_fail++; $display("FAIL prio_load: got we=%b d=%0d v=%h want 1/6/66", rf_we, rf_dest, rf_value); end
    next_cyc();
    n_chk++; if (hazard !== 1'b0 || count !== 2'd0)
      begin n_fail++; $display("FAIL prio_after: got hz=%b count=%0d want 0/0", hazard, count); end
  endtask

  task automatic test_squash();
    src1 = 4'd2; src2 = 4'd0;
    drive(1'b1, 4'd9, 32'h1, 1'b1, 4'd2, 32'h22);
    next_cyc();
    drive(1'b1, 4'd9, 32'h1, 1'b1, 4'd7, 32'h77);
    n_chk++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL squash_hazard_live: got %b want 1", hazard); end
    next_cyc();
    drive(1'b1, 4'd2, 32'h99, 1'b0, 4'd0, 32'd0);
    n_chk++; if (count !== 2'd2 || hazard !== 1'b1)
      begin n_fail++; $display("FAIL squash_pre_edge: got count=%0d hz=%b want 2/1", count, hazard); end
    next_cyc();
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    n_chk++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL squash_hazard_drop: got %b want 0", hazard); end
    n_chk++; if (rf_we !== 1'b0 || count !== 2'd2)
      begin n_fail++; $display("FAIL squash_dead_pop: got we=%b count=%0d want 0/2", rf_we, count); end
    next_cyc();
    src1 = 4'd7; #1;
    n_chk++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL squash_r7_hazard: got %b want 1", hazard); end
    n_chk++; if (rf_we !== 1'b1 || rf_dest !== 4'd7 || rf_value !== 32'h77 || count !== 2'd1)
      begin n_fail++; $display("FAIL squash_r7_write: got we=%b d=%0d v=%h c=%0d want 1/7/77/1", rf_we, rf_dest, rf_value, count); end
    next_cyc();
    n_chk++; if (count !== 2'd0) begin n_fail++; $display("FAIL squash_empty: got %0d want 0", count); end
  endtask

  task automatic test_full();
    src1 = 4'd0; src2 = 4'd0;
    drive(1'b1, 4'd15, 32'h1, 1'b1, 4'd10, 32'hA1);
    next_cyc();
    drive(1'b1, 4'd15, 32'h1, 1'b1, 4'd11, 32'hB1);
    n_chk++; if (ld_ready !== 1'b1 || count !== 2'd1)
      begin n_fail++; $display("FAIL full_half: got rdy=%b count=%0d want 1/1", ld_ready, count); end
    next_cyc();
    drive(1'b1, 4'd15, 32'h1, 1'b1, 4'd12, 32'hC1);
    n_chk++; if (ld_ready !== 1'b0 || count !== 2'd2)
      begin n_fail++; $display("FAIL full_not_ready: got rdy=%b count=%0d want 0/2", ld_ready, count); end
    next_cyc();
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd12, 32'hC1);
    n_chk++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_passthru: got %b want 0", ld_ready); end
    n_chk++; if (rf_we !== 1'b1 || rf_dest !== 4'd10 || rf_value !== 32'hA1)
      begin n_fail++; $display("FAIL full_pop10: got we=%b d=%0d v=%h want 1/10/a1", rf_we, rf_dest, rf_value); end
    next_cyc();
    drive(1'b1, 4'd15, 32'h1, 1'b1, 4'd12, 32'hC1);
    n_chk++; if (ld_ready !== 1'b1 || count !== 2'd1)
      begin n_fail++; $display("FAIL full_ready_again: got rdy=%b count=%0d want 1/1", ld_ready, count); end
    next_cyc();
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    n_chk++; if (count !== 2'd2 || rf_we !== 1'b1 || rf_dest !== 4'd11 || rf_value !== 32'hB1)
      begin n_fail++; $display("FAIL full_pop11: got c=%0d we=%b d=%0d v=%h want 2/1/11/b1", count, rf_we, rf_dest, rf_value); end
    next_cyc();
    n_chk++; if (count !== 2'd1 || rf_we !== 1'b1 || rf_dest !== 4'd12 || rf_value !== 32'hC1)
      begin n_fail++; $display("FAIL full_pop12: got c=%0d we=%b d=%0d v=%h want 1/1/12/c1", count, rf_we, rf_dest, rf_value); end
    next_cyc();
    n_chk++; if (count !== 2'd0) begin n_fail++; $display("FAIL full_empty: got %0d want 0", count); end
  endtask

  task automatic test_starve();
    drive(1'b1, 4'd15, 32'h1, 1'b1, 4'd4, 32'h44);
    next_cyc();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd15, 32'h1, 1'b0, 4'd0, 32'd0);
      n_chk++; if (stall_req !== 1'b0)
        begin n_fail++; $display("FAIL starve_early_%0d: got %b want 0", i, stall_req); end
      next_cyc();
    end
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    n_chk++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL starve_stall_rise: got %b want 1", stall_req); end
    n_chk++; if (rf_we !== 1'b1 || rf_dest !== 4'd4 || rf_value !== 32'h44)
      begin n_fail++; $display("FAIL starve_pop: got we=%b d=%0d v=%h want 1/4/44", rf_we, rf_dest, rf_value); end
    next_cyc();
    n_chk++; if (stall_req !== 1'b0 || count !== 2'd0)
      begin n_fail++; $display("FAIL starve_stall_fall: got st=%b c=%0d want 0/0", stall_req, count); end
  endtask

  task automatic test_reset_mid();
    src1 = 4'd13; src2 = 4'd0;
    drive(1'b1, 4'd15, 32'h1, 1'b1, 4'd13, 32'hD1);
    next_cyc();
    drive(1'b1, 4'd15, 32'h1, 1'b1, 4'd14, 32'hE1);
    next_cyc();
    drive(1'b1, 4'd15, 32'h1, 1'b0, 4'd0, 32'd0);
    n_chk++; if (count !== 2'd2 || hazard !== 1'b1)
      begin n_fail++; $display("FAIL rstmid_pre: got c=%0d hz=%b want 2/1", count, hazard); end
    rst = 1'b1; #1;
    n_chk++; if (count !== 2'd0 || ld_ready !== 1'b1 || hazard !== 1'b0 || stall_req !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_state: got c=%0d rdy=%b hz=%b st=%b want 0/1/0/0", count, ld_ready, hazard, stall_req); end
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_write: got %b want 0", rf_we); end
    next_cyc();
    rst = 1'b0; #1;
    n_chk++; if (rf_we !== 1'b0 || count !== 2'd0)
      begin n_fail++; $display("FAIL rstmid_after: got we=%b c=%0d want 0/0", rf_we, count); end
    next_cyc();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load_basic();
    test_pipe_priority();
    test_squash();
    test_full();
    test_starve();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback (WB stage output) and a variable-latency load-return path. Pipeline writes always win. Deferred load returns are held in a small FIFO and drained on idle write-port cycles. The block also squashes load returns overtaken by a younger pipeline write to the same register, reports pending-load hazards to the hazard unit, and raises a stall request when the FIFO is starved.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 4, register address width
- DEPTH, 2, load-return FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive blocked cycles before stall_req asserts

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pipe_wb_en  in  1  pipeline WB write request
- pipe_dest  in  ADDR_W  pipeline WB destination
- pipe_value  in  DATA_W  pipeline WB value
- ld_valid  in  1  load-return valid
- ld_dest  in  ADDR_W  load-return destination
- ld_value  in  DATA_W  load-return data
- ld_ready  out  1  FIFO can accept a load return this cycle
- src1, src2  in  ADDR_W  source registers of the instruction in decode
- hazard  out  1  src1 or src2 matches a live FIFO entry
- rf_we  out  1  register-file write enable
- rf_dest  out  ADDR_W  register-file write address
- rf_value  out  DATA_W  register-file write data
- stall_req  out  1  freeze pipeline so the FIFO can drain
- count  out  $clog2(DEPTH)+1  FIFO occupancy, including squashed entries

## Operation
- FIFO entry state: dest, value, live bit. Storage uses head and tail pointers that wrap modulo DEPTH, plus an occupancy counter.
- ld_ready = (count < DEPTH).
- Push occurs when ld_valid && ld_ready. A push always lands at the tail with live=1.
- When full, a same-cycle pop does not raise ld_ready; there is no pass-through.
- Write-port grant is combinational and follows this priority:
  - pipe_wb_en=1: rf_we=1, rf_dest=pipe_dest, rf_value=pipe_value. No pop.
  - Otherwise, if count>0: pop the head. rf_we = head.live, with head dest and value. A squashed head pops with rf_we=0 and consumes the cycle.
  - Otherwise: rf_we=0; rf_dest and rf_value are don't-care, driven 0.
- Squash: on every cycle with pipe_wb_en=1, every FIFO entry whose dest equals pipe_dest gets live cleared at the edge. Pipeline instructions are younger than any outstanding load.
  - A load pushed in the same cycle is NOT squashed; it is younger than that pipeline write.
- hazard = OR over live entries of (dest==src1 || dest==src2). A push in the current cycle is excluded; it is visible from the next cycle.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Starvation counter:
  - Increments on each cycle with count>0 && pipe_wb_en=1.
  - Clears on any pop, and whenever count==0.
  - Saturates at STARVE_MAX.
- stall_req:
  - Registered; set at the edge where the counter reaches STARVE_MAX.
  - Cleared at the edge of the next pop.
  - While stall_req=1 the pipeline drives pipe_wb_en=0; the bench asserts this.

## Timing
- Reset state (rst=1, asynchronous): count=0, pointers=0, all live=0, starvation counter=0, stall_req=0.
  - Consequently ld_ready=1 and hazard=0.
  - rf_we follows pipe_wb_en combinationally.
- Load latency: a load accepted at edge N writes the RF at the earliest in cycle N+1, provided pipe_wb_en=0 in that cycle.
- Pipeline writes have zero added latency; the combinational path is pipe_* → rf_*.
- Squash takes effect at the edge and is visible to hazard in the following cycle.
- stall_req rises one cycle after the STARVE_MAX-th consecutive blocked cycle. It falls one cycle after the pop.
- Mid-operation rst discards all FIFO contents; no RF write occurs for those entries.

## Test plan
- Reset, then ld_valid=1 with dest=3, value=0xAAAA, while pipe_wb_en=0 → next cycle rf_we=1, rf_dest=3, rf_value=0xAAAA, and count returns to 0.
- pipe_wb_en=1 (dest=5, value=0x11) in the same cycle as ld_valid (dest=6) → rf writes 5/0x11 that cycle and 6 the next cycle. hazard=1 for src1=6 only in between.
- Push loads to r2 and r7 with pipe_wb_en=1. The next cycle pipe_dest=2 → on drain, the r2 slot pops with rf_we=0 and r7 writes. hazard for src1=2 drops after the squash edge.
- Fill the FIFO (count=2) → ld_ready=0. With ld_valid held, nothing is lost. After one pop, ld_ready=1 the following cycle and the load is accepted.
- count>0 with pipe_wb_en=1 for 4 cycles → stall_req=1 on cycle 5. Drop pipe_wb_en → pop, and stall_req=0 on the next cycle.
- Assert rst with count=2 → count=0, ld_ready=1, hazard=0, stall_req=0 immediately, and no RF write from the discarded entries.
